// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the LFSR XOR stream cipher tiles (TX and RX).
package xor_cipher_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned SYNC_W = 16;
  localparam int unsigned CFG_W  = 64;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LFSR_W-1:0] TAPS_DEFAULT_C = 32'h0000_0060;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT_C = 32'h0000_0001;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_e;

  // Serial config image: seed occupies the upper half, shifted out first.
  typedef struct packed {
    logic [LFSR_W-1:0] seed;
    logic [LFSR_W-1:0] taps;
  } cipher_cfg_t;

  // An all-zero seed would lock the LFSR at zero, so substitute 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed_value(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? LFSR_W'(1) : seed;
  endfunction

endpackage

// File: rtl/rx_keystream_lfsr.sv
// Galois right-shift LFSR regenerating the transmitter keystream.
module rx_keystream_lfsr
  import xor_cipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  input  logic [LFSR_W-1:0] taps,
  output logic              k
);

  logic [LFSR_W-1:0] lfsr_q;

  // Load wins over advance so a fresh frame always starts from the seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_W'(1);
    end else if (load) begin
      lfsr_q <= lfsr_seed_value(seed);
    end else if (advance) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? taps : '0);
    end
  end

  assign k = lfsr_q[0];

endmodule

// File: rtl/xor_decipher_rx.sv
// Receive side of the XOR stream cipher: sync hunt, keystream regeneration,
// payload decryption and the daisy-chained seed/taps config shifter.
module xor_decipher_rx
  import xor_cipher_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD    = 16'hA5C3,
  parameter int unsigned       PAYLOAD_LEN  = 64,
  parameter logic [LFSR_W-1:0] TAPS_DEFAULT = TAPS_DEFAULT_C,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic dout,
  output logic dout_valid,
  output logic frame_done,
  output logic sync_lock,
  input  logic cfg_en,
  input  logic cfg_i,
  output logic cfg_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_LEN - 1);

  rx_state_e         state, state_d;
  logic [SYNC_W-1:0] sync_sr, sync_sr_d, sync_shifted;
  logic [CNT_W-1:0]  count, count_d;
  logic              dout_d, dout_valid_d, frame_done_d, sync_lock_d;
  logic              lfsr_load, lfsr_advance, k;
  cipher_cfg_t       cfg_reg;

  // Config chain: MSB leaves on cfg_o before each shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_reg <= '{seed: SEED_DEFAULT, taps: TAPS_DEFAULT};
    end else if (cfg_en) begin
      cfg_reg <= cipher_cfg_t'({cfg_reg[CFG_W-2:0], cfg_i});
    end
  end

  assign cfg_o = cfg_reg[CFG_W-1];

  rx_keystream_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (cfg_reg.seed),
    .advance (lfsr_advance),
    .taps    (cfg_reg.taps),
    .k       (k)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      sync_sr    <= '0;
      count      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      sync_lock  <= 1'b0;
    end else begin
      state      <= state_d;
      sync_sr    <= sync_sr_d;
      count      <= count_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      frame_done <= frame_done_d;
      sync_lock  <= sync_lock_d;
    end
  end

  assign sync_shifted = {sync_sr[SYNC_W-2:0], din};

  // Next-state and output decode; cfg activity aborts everything.
  always_comb begin
    state_d      = state;
    sync_sr_d    = sync_sr;
    count_d      = count;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;

    if (cfg_en) begin
      state_d   = HUNT;
      sync_sr_d = '0;
    end else begin
      case (state)
        HUNT: begin
          if (din_valid) begin
            sync_sr_d = sync_shifted;
            if (sync_shifted == SYNC_WORD) begin
              lfsr_load = 1'b1;
              count_d   = '0;
              state_d   = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (din_valid) begin
            dout_d       = din ^ k;
            dout_valid_d = 1'b1;
            lfsr_advance = 1'b1;
            count_d      = count + CNT_W'(1);
            if (count == LAST_BIT) begin
              frame_done_d = 1'b1;
              sync_sr_d    = '0;
              count_d      = '0;
              state_d      = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    sync_lock_d = (state_d == PAYLOAD);
  end

endmodule

// File: tb/tb_xor_decipher_rx.sv
// Scoreboard bench for xor_decipher_rx with 8-bit frames and hand-computed vectors.
module tb_xor_decipher_rx;

  logic clk = 1'b0;
  logic rst, din, din_valid, cfg_en, cfg_i;
  logic dout, dout_valid, frame_done, sync_lock, cfg_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  xor_decipher_rx #(.PAYLOAD_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .sync_lock  (sync_lock),
    .cfg_en     (cfg_en),
    .cfg_i      (cfg_i),
    .cfg_o      (cfg_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst && dout_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: got dout=%0b fd=%0b expected no output at %0t",
                   dout, frame_done, $time);
        end else begin
          e = exp_q.pop_front();
          if ({dout, frame_done} !== e) begin
            miscompares++;
            $display("FAIL dout/frame_done: got %0b%0b expected %0b%0b at %0t",
                     dout, frame_done, e[1], e[0], $time);
          end
        end
      end else if (rst && frame_done) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_done_alone: got 1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic send_bit(input logic b, input logic v);
    din = b; din_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], 1'b1);
  endtask

  task automatic send_sync();
    send_word(32'h0000_A5C3, 16);
  endtask

  // Ciphertext c and expected plaintext p, both sent MSB first.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] p, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back({p[i], (i == 0) ? 1'b1 : 1'b0});
      send_bit(c[i], 1'b1);
      if (gaps) send_bit(~c[i], 1'b0);
    end
  endtask

  task automatic cfg_shift(input logic [63:0] val, input logic [63:0] prev);
    for (int i = 63; i >= 0; i--) begin
      cfg_en = 1'b1; cfg_i = val[i]; din_valid = 1'b0;
      check("cfg_o_replay", 64'(cfg_o), 64'(prev[i]));
      @(posedge clk); #1;
    end
    cfg_en = 1'b0; cfg_i = 1'b0;
  endtask

  initial begin
    logic [15:0] sw;
    rst = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_sync_lock", 64'(sync_lock), 64'd0);
    check("rst_cfg_o", 64'(cfg_o), 64'd0);
    rst = 1'b1;
    idle(2);

    // 1: basic frame, zero ciphertext exposes keystream 1,0,0,0,0,0,1,1
    sw = 16'hA5C3;
    for (int i = 15; i >= 1; i--) send_bit(sw[i], 1'b1);
    check("lock_before_last_sync_bit", 64'(sync_lock), 64'd0);
    send_bit(sw[0], 1'b1);
    check("lock_after_sync", 64'(sync_lock), 64'd1);
    send_frame(8'h00, 8'b1000_0011, 1'b0);
    check("lock_drop_after_frame", 64'(sync_lock), 64'd0);
    idle(3);

    // 2: same frame with stalls between payload bits
    send_sync();
    send_frame(8'h00, 8'b1000_0011, 1'b1);
    idle(3);

    // 3: near-miss noise must not lock
    send_word(32'hA5C2_5A3C, 32);
    check("noise_no_lock", 64'(sync_lock), 64'd0);
    send_sync();
    check("lock_after_true_sync", 64'(sync_lock), 64'd1);
    send_frame(8'h00, 8'b1000_0011, 1'b0);

    // 6: back-to-back frames, keystream restarts each frame
    send_sync();
    send_frame(8'h00, 8'b1000_0011, 1'b0);
    send_sync();
    send_frame(8'b0010_0110, 8'b1010_0101, 1'b0);
    idle(3);

    // 5a: cfg pulse at payload bit 3 aborts; cfg becomes seed=2, taps=C0
    send_sync();
    exp_q.push_back(2'b10); send_bit(1'b0, 1'b1);
    exp_q.push_back(2'b00); send_bit(1'b0, 1'b1);
    exp_q.push_back(2'b00); send_bit(1'b0, 1'b1);
    cfg_en = 1'b1; cfg_i = 1'b0;
    send_bit(1'b0, 1'b1);
    cfg_en = 1'b0;
    check("abort_lock", 64'(sync_lock), 64'd0);
    send_word(32'h0000_00FF, 8);
    check("no_relock_without_sync", 64'(sync_lock), 64'd0);
    idle(2);

    // 5b: new key gives keystream 0,1,0,0,0; reset at bit 5
    send_sync();
    exp_q.push_back(2'b10); send_bit(1'b1, 1'b1);
    exp_q.push_back(2'b00); send_bit(1'b1, 1'b1);
    exp_q.push_back(2'b10); send_bit(1'b1, 1'b1);
    exp_q.push_back(2'b10); send_bit(1'b1, 1'b1);
    exp_q.push_back(2'b10); send_bit(1'b1, 1'b1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_dout_valid", 64'(dout_valid), 64'd0);
    check("midrst_frame_done", 64'(frame_done), 64'd0);
    check("midrst_sync_lock", 64'(sync_lock), 64'd0);
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // 4: load seed=1, taps=B4; old defaults replay on cfg_o
    cfg_shift(64'h0000_0001_0000_00B4, 64'h0000_0001_0000_0060);
    check("cfg_o_after_load", 64'(cfg_o), 64'd0);
    send_sync();
    send_frame(8'b0101_1110, 8'b1100_1010, 1'b0);
    idle(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
